multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder: it decodes the instruction opcode held in the IR and sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath enables, the mux selects, and the 2-bit aluOp that the ALU control stage consumes. Supported instructions: R-type, lw, sw, beq, j, addi.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  synchronous active-low reset
opCode  input  6  instruction[31:26] from the IR
pcWrite  output  1  unconditional PC write
pcWriteCond  output  1  PC write when ALU zero
iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
memRead  output  1  memory read strobe
memWrite  output  1  memory write strobe
memToReg  output  1  register write data select: 1 = MDR
irWrite  output  1  IR load
regDst  output  1  destination register: 1 = rd, 0 = rt
regWrite  output  1  register file write
aluSrcA  output  1  ALU A select: 0 = PC, 1 = reg A
aluSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
aluOp  output  2  to ALU control: 00 = add, 01 = sub, 10 = funct
pcSource  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
illegalOp  output  1  one-cycle pulse for an unsupported opcode
state  output  4  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rstN is synchronous and active-low.
- Reset:
  - While rstN = 0, all outputs are forced to 0 combinationally.
  - On each rising clk edge with rstN = 0, state loads FETCH (0).
  - On the first edge after rstN goes high, the FSM leaves FETCH normally.
  - Reset asserted mid-instruction abandons that instruction; no partial write occurs after the reset edge.
- Output decode: Moore. All outputs are decoded from state only. Any signal not listed for a state is 0.
- State encoding and outputs:
  - 0 FETCH: memRead, irWrite, pcWrite = 1; iorD = 0; aluSrcA = 0; aluSrcB = 01; aluOp = 00; pcSource = 00.
  - 1 DECODE: aluSrcA = 0; aluSrcB = 11; aluOp = 00.
  - 2 MEMADDR: aluSrcA = 1; aluSrcB = 10; aluOp = 00.
  - 3 MEMREAD: memRead = 1; iorD = 1.
  - 4 MEMWB: regWrite = 1; memToReg = 1; regDst = 0.
  - 5 MEMWRITE: memWrite = 1; iorD = 1.
  - 6 EXECUTE: aluSrcA = 1; aluSrcB = 00; aluOp = 10.
  - 7 RCOMPLETE: regWrite = 1; regDst = 1; memToReg = 0.
  - 8 BRANCH: aluSrcA = 1; aluSrcB = 00; aluOp = 01; pcWriteCond = 1; pcSource = 01.
  - 9 JUMP: pcWrite = 1; pcSource = 10.
  - 10 ADDIEXEC: aluSrcA = 1; aluSrcB = 10; aluOp = 00.
  - 11 ADDIWB: regWrite = 1; regDst = 0; memToReg = 0.
  - 12–15: unused. Outputs are all 0 and the next state is FETCH (recovery).
- Transitions:
  - FETCH -> DECODE, always.
  - DECODE dispatches on opCode:
    - lw or sw -> MEMADDR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDIEXEC
    - any other opcode -> FETCH, with illegalOp = 1 registered for exactly the following cycle.
  - MEMADDR: lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTE -> RCOMPLETE.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWRITE, RCOMPLETE, BRANCH, JUMP, ADDIWB -> FETCH.
- opCode sampling: opCode is sampled only in DECODE and MEMADDR. It is stable there because the IR loads only in FETCH. Changes to opCode in any other state have no effect.
- Latency (cycles from FETCH to the next FETCH): lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- illegalOp: registered, reset to 0. It is never high for two consecutive cycles unless illegal opcodes are decoded back-to-back (minimum spacing 2 cycles).
- Exclusivity: memRead and memWrite are never both 1. pcWrite and pcWriteCond are never both 1.

Test Plan:
- rstN = 0 for 3 cycles, opCode = 6'b100011 -> all outputs 0 during reset; state = 0 on the first cycle after release, with memRead = irWrite = pcWrite = 1.
- lw (100011) -> state sequence 0, 1, 2, 3, 4, 0. regWrite = memToReg = 1 only in state 4; aluOp = 00 throughout.
- R-type (000000), then sw (101011) -> R-type visits 0, 1, 6, 7 with aluOp = 10 in state 6 and regDst = 1 in state 7. sw then visits 0, 1, 2, 5 with memWrite = 1 only in state 5.
- beq (000100) and j (000010) -> beq: 0, 1, 8 with aluOp = 01 and pcWriteCond = 1. j: 0, 1, 9 with pcWrite = 1 and pcSource = 10. Each takes 3 cycles.
- Opcode 6'b111111 -> 0, 1, 0; illegalOp = 1 for exactly one cycle (the cycle after DECODE); no regWrite or memWrite asserted.
- rstN pulled low for 1 cycle while in state 3 (lw MEMREAD) -> the next state is 0, no regWrite occurs, and a fresh fetch proceeds normally.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - opcode in / datapath control out bundle for the multicycle controller
interface multicycle_ctrl_if;
  logic [5:0] opCode;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       memToReg;
  logic       irWrite;
  logic       regDst;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] pcSource;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  opCode,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp, state
  );

  modport slave (
    output opCode,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main Moore control FSM of the multicycle MIPS datapath
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic               clk,
  input  logic               rstN,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE   = 4'd6,
    S_RCOMPLETE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDIEXEC  = 4'd10,
    S_ADDIWB    = 4'd11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       illegal_q;
  logic       illegal_d;

  logic       pc_write;
  logic       pc_write_cond;
  logic       ior_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opCode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR:  state_d = (bus.opCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_RCOMPLETE;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RCOMPLETE: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB:   reg_write = 1'b1;
      default: ;
    endcase
  end

  // Reset gates every output so nothing reaches the datapath before the first FETCH edge.
  assign bus.pcWrite     = rstN & pc_write;
  assign bus.pcWriteCond = rstN & pc_write_cond;
  assign bus.iorD        = rstN & ior_d;
  assign bus.memRead     = rstN & mem_read;
  assign bus.memWrite    = rstN & mem_write;
  assign bus.memToReg    = rstN & mem_to_reg;
  assign bus.irWrite     = rstN & ir_write;
  assign bus.regDst      = rstN & reg_dst;
  assign bus.regWrite    = rstN & reg_write;
  assign bus.aluSrcA     = rstN & alu_src_a;
  assign bus.aluSrcB     = rstN ? alu_src_b : 2'b00;
  assign bus.aluOp       = rstN ? alu_op : 2'b00;
  assign bus.pcSource    = rstN ? pc_source : 2'b00;
  assign bus.illegalOp   = rstN & illegal_q;
  assign bus.state       = rstN ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;
  typedef int path_t[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   exp_ill = 1'b0;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rstN(rstN), .bus(bus));

  always #5 clk = ~clk;

  wire [15:0] obs = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead, bus.memWrite,
                     bus.memToReg, bus.irWrite, bus.regDst, bus.regWrite, bus.aluSrcA,
                     bus.aluSrcB, bus.aluOp, bus.pcSource};

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  // Instruction-level view: which steps each opcode walks through
  function automatic path_t exp_path(input logic [5:0] op);
    path_t p;
    p = {0, 1};
    if (op == LW) p = {p, 2, 3, 4};
    else if (op == SW) p = {p, 2, 5};
    else if (op == RT) p = {p, 6, 7};
    else if (op == BEQ) p.push_back(8);
    else if (op == JMP) p.push_back(9);
    else if (op == ADDI) p = {p, 10, 11};
    return p;
  endfunction

  function automatic logic [15:0] exp_out(input int s);
    logic pw, pwc, iord, mr, mw, m2r, irw, rd, rw, sa;
    logic [1:0] sb, aop, psrc;
    {pw, pwc, iord, mr, mw, m2r, irw, rd, rw, sa} = '0;
    sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mr = 1; irw = 1; pw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, m2r, irw, rd, rw, sa, sb, aop, psrc};
  endfunction

  // Entered just after the edge into FETCH; returns just after the edge into the next FETCH.
  task automatic exec_instr(input logic [5:0] op, input bit scramble);
    path_t p;
    p = exp_path(op);
    for (int i = 0; i < p.size(); i++) begin
      if (p[i] == 0) bus.opCode = op;
      else if (scramble && p[i] != 1 && p[i] != 2) bus.opCode = 6'($urandom);
      @(negedge clk);
      checks++;
      if (bus.state !== 4'(p[i])) begin
        errors++;
        $display("FAIL state op=%b step=%0d: got %0d expected %0d", op, i, bus.state, p[i]);
      end
      checks++;
      if (obs !== exp_out(p[i])) begin
        errors++;
        $display("FAIL outputs op=%b state=%0d: got %h expected %h", op, p[i], obs, exp_out(p[i]));
      end
      checks++;
      if (bus.illegalOp !== exp_ill) begin
        errors++;
        $display("FAIL illegalOp op=%b step=%0d: got %b expected %b", op, i, bus.illegalOp, exp_ill);
      end
      checks++;
      if ((bus.memRead & bus.memWrite) !== 1'b0 || (bus.pcWrite & bus.pcWriteCond) !== 1'b0) begin
        errors++;
        $display("FAIL exclusivity state=%0d: got %h expected no overlap", p[i], obs);
      end
      exp_ill = (p[i] == 1) && !is_legal(op);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.opCode = LW;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 16'h0 || bus.state !== 4'd0 || bus.illegalOp !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d: got %h/%0d/%b expected 0/0/0", i, obs, bus.state, bus.illegalOp);
      end
      @(posedge clk);
      #1;
    end
    rstN = 1'b1;
    exp_ill = 1'b0;
  endtask

  task automatic test_lw();
    exec_instr(LW, 1'b0);
    exec_instr(LW, 1'b1);
  endtask

  task automatic test_rtype_sw();
    exec_instr(RT, 1'b0);
    exec_instr(SW, 1'b0);
    exec_instr(ADDI, 1'b1);
  endtask

  task automatic test_beq_j();
    exec_instr(BEQ, 1'b0);
    exec_instr(JMP, 1'b1);
  endtask

  task automatic test_illegal();
    exec_instr(6'b111111, 1'b0);
    exec_instr(6'b111111, 1'b0);
    exec_instr(6'b000001, 1'b0);
    exec_instr(LW, 1'b0);
  endtask

  task automatic test_reset_mid_instr();
    path_t p;
    p = {0, 1, 2, 3};
    bus.opCode = LW;
    for (int i = 0; i < p.size(); i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'(p[i]) || obs !== exp_out(p[i])) begin
        errors++;
        $display("FAIL midreset_pre state=%0d: got %0d/%h expected %0d/%h", p[i], bus.state, obs, p[i], exp_out(p[i]));
      end
      if (i < p.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (obs !== 16'h0 || bus.regWrite !== 1'b0) begin
      errors++;
      $display("FAIL midreset_gate: got %h expected 0000", obs);
    end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    exp_ill = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.regWrite !== 1'b0) begin
      errors++;
      $display("FAIL midreset_recover: got state %0d regWrite %b expected 0/0", bus.state, bus.regWrite);
    end
    exec_instr(LW, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{LW, SW, RT, BEQ, JMP, ADDI};
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      exec_instr(op, 1'($urandom));
    end
  endtask

  initial begin
    bus.opCode = 6'b0;
    test_reset();
    test_lw();
    test_rtype_sw();
    test_beq_j();
    test_illegal();
    test_reset_mid_instr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
